scan_chain_ctrl: RTL and testbench

- Parametrised successor to the single-chain mux-D scan flop arrangement used around our ISCAS benchmark cores.
- Holds NUM_CHAINS parallel scan chains of CHAIN_LEN mux-D flops that sit between a combinational core's next-state outputs and its present-state inputs.
- Supports manual shift/capture via SE, and an autonomous controller that runs load/capture/unload sequences for a programmed number of patterns.
- Compacts all scan-out streams into a MISR signature.

---
 rtl/scan_pkg.sv | 17 +
 rtl/scan_chain_scan_chain.sv | 41 ++++
 rtl/scan_chain_ctrl.sv | 146 ++++++++++++++
 tb/tb_scan_chain_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared definitions for the scan chain controller: FSM encodings, default MISR
// feedback taps and the flattened scan-flop vector width.
package scan_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SHIFT   = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_UNLOAD  = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic [15:0] DEFAULT_MISR_POLY = 16'h1021;

    function automatic int flat_width(input int num_chains, input int chain_len);
        return num_chains * chain_len;
    endfunction

endpackage

// File: rtl/scan_chain_scan_chain.sv
// One mux-D scan chain: each flop either holds, shifts toward the SO end,
// or captures the functional next-state from the core.
module scan_chain #(
    parameter int CHAIN_LEN = 3
) (
    input  logic                 ck,
    input  logic                 rst,
    input  logic                 hold,
    input  logic                 se,
    input  logic [CHAIN_LEN-1:0] d,
    input  logic                 si,
    output logic [CHAIN_LEN-1:0] q,
    output logic                 so
);

    logic [CHAIN_LEN-1:0] q_q;
    logic [CHAIN_LEN-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (hold) begin
            q_d = q_q;
        end else if (se) begin
            q_d = {q_q[CHAIN_LEN-2:0], si};
        end else begin
            q_d = d;
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign so = q_q[CHAIN_LEN-1];

endmodule

// File: rtl/scan_chain_ctrl.sv
// Parallel mux-D scan chains with an autonomous load/capture/unload sequencer
// and a MISR that compacts every scan-out stream into one signature.
module scan_chain_ctrl
    import scan_pkg::*;
#(
    parameter int                NUM_CHAINS = 2,
    parameter int                CHAIN_LEN  = 3,
    parameter int                PAT_W      = 8,
    parameter int                MISR_W     = 16,
    parameter logic [MISR_W-1:0] MISR_POLY  = MISR_W'(DEFAULT_MISR_POLY)
) (
    input  logic                                         CK,
    input  logic                                         RST,
    input  logic [flat_width(NUM_CHAINS, CHAIN_LEN)-1:0] D,
    output logic [flat_width(NUM_CHAINS, CHAIN_LEN)-1:0] Q,
    input  logic [NUM_CHAINS-1:0]                        SI,
    output logic [NUM_CHAINS-1:0]                        SO,
    input  logic                                         SE,
    input  logic                                         HOLD,
    input  logic [PAT_W-1:0]                             num_patterns,
    input  logic                                         auto_start,
    output logic                                         busy,
    output logic                                         done,
    output logic [PAT_W-1:0]                             pat_count,
    output logic [MISR_W-1:0]                            misr_sig
);

    localparam int CNT_W = (CHAIN_LEN > 2) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  shift_cnt_q, shift_cnt_d;
    logic [PAT_W-1:0]  pat_count_q, pat_count_d;
    logic [MISR_W-1:0] misr_q, misr_d;
    logic              unload_valid_q, unload_valid_d;
    logic              se_eff;
    logic [MISR_W-1:0] misr_next;

    for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_chain
        scan_chain #(
            .CHAIN_LEN(CHAIN_LEN)
        ) u_chain (
            .ck  (CK),
            .rst (RST),
            .hold(HOLD),
            .se  (se_eff),
            .d   (D[c*CHAIN_LEN +: CHAIN_LEN]),
            .si  (SI[c]),
            .q   (Q[c*CHAIN_LEN +: CHAIN_LEN]),
            .so  (SO[c])
        );
    end

    // SO is taken before this edge's shift, so the MISR sees the bit leaving the chain.
    assign misr_next = {misr_q[MISR_W-2:0], 1'b0}
                     ^ (misr_q[MISR_W-1] ? MISR_POLY : '0)
                     ^ MISR_W'(SO);

    always_comb begin
        state_d        = state_q;
        shift_cnt_d    = shift_cnt_q;
        pat_count_d    = pat_count_q;
        misr_d         = misr_q;
        unload_valid_d = unload_valid_q;
        se_eff         = SE;

        case (state_q)
            ST_IDLE: begin
                se_eff = SE;
                if (auto_start && (num_patterns != '0)) begin
                    state_d        = ST_SHIFT;
                    shift_cnt_d    = '0;
                    pat_count_d    = '0;
                    misr_d         = '0;
                    unload_valid_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                se_eff = 1'b1;
                if (shift_cnt_q == CNT_LAST) begin
                    state_d     = ST_CAPTURE;
                    shift_cnt_d = '0;
                end else begin
                    shift_cnt_d = shift_cnt_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                se_eff         = 1'b0;
                pat_count_d    = pat_count_q + 1'b1;
                unload_valid_d = 1'b1;
                state_d        = (pat_count_d == num_patterns) ? ST_UNLOAD : ST_SHIFT;
            end
            ST_UNLOAD: begin
                se_eff = 1'b1;
                if (shift_cnt_q == CNT_LAST) begin
                    state_d     = ST_DONE;
                    shift_cnt_d = '0;
                end else begin
                    shift_cnt_d = shift_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                se_eff  = SE;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (((state_q == ST_SHIFT) || (state_q == ST_UNLOAD)) && unload_valid_q) begin
            misr_d = misr_next;
        end

        // HOLD freezes the sequencer along with the chains.
        if (HOLD) begin
            state_d        = state_q;
            shift_cnt_d    = shift_cnt_q;
            pat_count_d    = pat_count_q;
            misr_d         = misr_q;
            unload_valid_d = unload_valid_q;
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q        <= ST_IDLE;
            shift_cnt_q    <= '0;
            pat_count_q    <= '0;
            misr_q         <= '0;
            unload_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_cnt_q    <= shift_cnt_d;
            pat_count_q    <= pat_count_d;
            misr_q         <= misr_d;
            unload_valid_q <= unload_valid_d;
        end
    end

    assign busy      = (state_q == ST_SHIFT) || (state_q == ST_CAPTURE) || (state_q == ST_UNLOAD);
    assign done      = (state_q == ST_DONE);
    assign pat_count = pat_count_q;
    assign misr_sig  = misr_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl: manual shift/capture checks plus a
// scoreboard that checks each completed auto run when done pulses.
module tb_scan_chain_ctrl;

    logic       CK;
    logic       RST;
    logic [5:0] D;
    logic [5:0] Q;
    logic [1:0] SI;
    logic [1:0] SO;
    logic       SE;
    logic       HOLD;
    logic [7:0] numPatterns;
    logic       autoStart;
    logic       busy;
    logic       done;
    logic [7:0] patCount;
    logic [15:0] misrSig;

    typedef struct packed {
        logic [7:0]  pat;
        logic [15:0] misr;
        logic [31:0] busyLen;
    } run_exp_t;

    run_exp_t expQ[$];
    int checkCount = 0;
    int errorCount = 0;
    int doneCount  = 0;
    int busyRun    = 0;

    scan_chain_ctrl #(
        .NUM_CHAINS(2),
        .CHAIN_LEN (3),
        .PAT_W     (8),
        .MISR_W    (16),
        .MISR_POLY (16'h1021)
    ) dut (
        .CK          (CK),
        .RST         (RST),
        .D           (D),
        .Q           (Q),
        .SI          (SI),
        .SO          (SO),
        .SE          (SE),
        .HOLD        (HOLD),
        .num_patterns(numPatterns),
        .auto_start  (autoStart),
        .busy        (busy),
        .done        (done),
        .pat_count   (patCount),
        .misr_sig    (misrSig)
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic se, input logic [1:0] si, input logic [5:0] d,
                                 input logic hold, input logic [7:0] num, input logic start);
        SE          = se;
        SI          = si;
        D           = d;
        HOLD        = hold;
        numPatterns = num;
        autoStart   = start;
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic waitDone(input string name, input int budget);
        int  seen = doneCount;
        logic ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (doneCount != seen) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput(name, {31'b0, ok}, 32'd1);
    endtask

    // Monitor: measures each busy window and checks the run result on done.
    always @(negedge CK) begin
        if (RST) begin
            busyRun = 0;
        end else if (done === 1'b1) begin
            doneCount++;
            if (expQ.size() == 0) begin
                checkCount++;
                errorCount++;
                $display("[TB] FAIL unexpected_done actual=1 expected=0");
            end else begin
                run_exp_t e;
                e = expQ.pop_front();
                checkOutput("run_pat_count", {24'b0, patCount}, {24'b0, e.pat});
                checkOutput("run_misr", {16'b0, misrSig}, {16'b0, e.misr});
                checkOutput("run_busy_len", busyRun, e.busyLen);
                checkOutput("busy_low_at_done", {31'b0, busy}, 32'd0);
            end
            busyRun = 0;
        end else if (busy === 1'b1) begin
            busyRun++;
        end else begin
            busyRun = 0;
        end
    end

    initial begin
        RST = 1'b1;
        applyStimulus(1'b0, 2'b00, 6'b0, 1'b0, 8'd0, 1'b0);
        tick();
        tick();
        RST = 1'b0;
        checkOutput("reset_q", {26'b0, Q}, 32'h0);
        checkOutput("reset_so", {30'b0, SO}, 32'h0);
        checkOutput("reset_busy", {31'b0, busy}, 32'h0);
        checkOutput("reset_done", {31'b0, done}, 32'h0);
        checkOutput("reset_pat", {24'b0, patCount}, 32'h0);
        checkOutput("reset_misr", {16'b0, misrSig}, 32'h0);

        // Manual shift of three scan-in vectors
        applyStimulus(1'b1, 2'b01, 6'b0, 1'b0, 8'd0, 1'b0); tick();
        applyStimulus(1'b1, 2'b10, 6'b0, 1'b0, 8'd0, 1'b0); tick();
        applyStimulus(1'b1, 2'b11, 6'b0, 1'b0, 8'd0, 1'b0); tick();
        checkOutput("manual_shift_q", {26'b0, Q}, 32'h1D);
        checkOutput("manual_shift_so", {30'b0, SO}, 32'h1);
        checkOutput("manual_shift_misr", {16'b0, misrSig}, 32'h0);

        applyStimulus(1'b0, 2'b00, 6'b110010, 1'b0, 8'd0, 1'b0); tick();
        checkOutput("manual_capture_q", {26'b0, Q}, 32'h32);
        applyStimulus(1'b1, 2'b11, 6'b000000, 1'b1, 8'd0, 1'b0); tick();
        checkOutput("hold_q", {26'b0, Q}, 32'h32);

        // Auto run A: two patterns of 100_100, expected signature 0x006C
        expQ.push_back('{pat: 8'd2, misr: 16'h006C, busyLen: 32'd11});
        applyStimulus(1'b0, 2'b00, 6'b100100, 1'b0, 8'd2, 1'b1); tick();
        autoStart = 1'b0;
        checkOutput("runA_busy_start", {31'b0, busy}, 32'h1);
        repeat (4) tick();
        checkOutput("runA_pat_after_cap1", {24'b0, patCount}, 32'd1);
        repeat (4) tick();
        checkOutput("runA_pat_after_cap2", {24'b0, patCount}, 32'd2);
        waitDone("runA_done_seen", 10);
        checkOutput("runA_done_one_cycle", {31'b0, done}, 32'h0);
        checkOutput("runA_misr_held", {16'b0, misrSig}, 32'h006C);

        // Auto run B: same data with SE toggling and a restart attempt mid-run
        expQ.push_back('{pat: 8'd2, misr: 16'h006C, busyLen: 32'd11});
        applyStimulus(1'b0, 2'b00, 6'b100100, 1'b0, 8'd2, 1'b1); tick();
        for (int i = 1; i <= 8; i++) begin
            SE        = i[0];
            autoStart = (i == 5);
            tick();
        end
        autoStart = 1'b0;
        SE        = 1'b0;
        waitDone("runB_done_seen", 10);
        checkOutput("runB_pat_final", {24'b0, patCount}, 32'd2);

        // MISR run: one pattern of all ones -> 0x0003, 0x0005, 0x0009
        expQ.push_back('{pat: 8'd1, misr: 16'h0009, busyLen: 32'd7});
        applyStimulus(1'b0, 2'b00, 6'b111111, 1'b0, 8'd1, 1'b1); tick();
        autoStart = 1'b0;
        checkOutput("misr_cleared_at_start", {16'b0, misrSig}, 32'h0);
        repeat (5) tick();
        checkOutput("misr_step1", {16'b0, misrSig}, 32'h0003);
        tick();
        checkOutput("misr_step2", {16'b0, misrSig}, 32'h0005);
        waitDone("misr_done_seen", 5);
        checkOutput("misr_final", {16'b0, misrSig}, 32'h0009);

        // Reset during the second SHIFT cycle aborts without a done pulse
        applyStimulus(1'b0, 2'b11, 6'b000000, 1'b0, 8'd2, 1'b1); tick();
        autoStart = 1'b0;
        tick();
        checkOutput("abort_q_before_reset", {26'b0, Q}, 32'h09);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checkOutput("abort_q", {26'b0, Q}, 32'h0);
        checkOutput("abort_busy", {31'b0, busy}, 32'h0);
        checkOutput("abort_pat", {24'b0, patCount}, 32'h0);
        checkOutput("abort_done", {31'b0, done}, 32'h0);
        repeat (15) tick();
        checkOutput("abort_stays_idle", {31'b0, busy}, 32'h0);

        expQ.push_back('{pat: 8'd1, misr: 16'h0009, busyLen: 32'd7});
        applyStimulus(1'b0, 2'b00, 6'b111111, 1'b0, 8'd1, 1'b1); tick();
        autoStart = 1'b0;
        waitDone("post_abort_done_seen", 15);

        // Start with zero patterns is ignored; manual shift leaves the signature alone
        applyStimulus(1'b0, 2'b00, 6'b000000, 1'b0, 8'd0, 1'b1); tick();
        autoStart = 1'b0;
        checkOutput("zero_pat_busy", {31'b0, busy}, 32'h0);
        tick();
        checkOutput("zero_pat_busy_later", {31'b0, busy}, 32'h0);
        checkOutput("zero_pat_count_kept", {24'b0, patCount}, 32'd1);
        applyStimulus(1'b1, 2'b11, 6'b000000, 1'b0, 8'd0, 1'b0); tick(); tick();
        checkOutput("idle_shift_misr_kept", {16'b0, misrSig}, 32'h0009);
        checkOutput("idle_shift_so", {30'b0, SO}, 32'h0);
        tick();
        checkOutput("idle_shift_so_third", {30'b0, SO}, 32'h3);

        SE = 1'b0;
        tick();
        checkOutput("scoreboard_empty", expQ.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
